// File: rtl/hazard_unit.sv
// Pipeline hazard unit: memory-wait stall FSM, load-use/RAW stalls, branch flushes, forwarding.
// Build option: define HAZARD_FORWARD_EN to enable E-stage forwarding; otherwise RAW hazards stall.
module hazard_unit #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D_i,
    input  logic [4:0]       Rs2D_i,
    input  logic [4:0]       Rs1E_i,
    input  logic [4:0]       Rs2E_i,
    input  logic [4:0]       RdE_i,
    input  logic             RegWriteE_i,
    input  logic [1:0]       ResultSrcE_i,
    input  logic [4:0]       RdM_i,
    input  logic             RegWriteM_i,
    input  logic [4:0]       RdW_i,
    input  logic             RegWriteW_i,
    input  logic             PCSrcE_i,
    input  logic             MemReqM_i,
    input  logic             MemReadyM_i,
    output logic             StallF_o,
    output logic             StallD_o,
    output logic             StallE_o,
    output logic             StallM_o,
    output logic             FlushD_o,
    output logic             FlushE_o,
    output logic             BubbleW_o,
    output logic [1:0]       ForwardAE_o,
    output logic [1:0]       ForwardBE_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned      WaitW    = $clog2(WAIT_MAX + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_MAX - 1);

    typedef enum logic [0:0] {StRun, StMemWait} state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic mem_busy;
    logic ld_use;
    logic raw_stall;

    // Memory stall is zero-latency: the request cycle itself already stalls.
    assign mem_busy = (state_q == StMemWait) || (MemReqM_i && !MemReadyM_i);

    assign ld_use = RegWriteE_i && (ResultSrcE_i == 2'b01) && (RdE_i != 5'd0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

`ifdef HAZARD_FORWARD_EN
    assign raw_stall = ld_use;

    always_comb begin
        ForwardAE_o = 2'b00;
        if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == Rs1E_i)) begin
            ForwardAE_o = 2'b10;
        end else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == Rs1E_i)) begin
            ForwardAE_o = 2'b01;
        end
        ForwardBE_o = 2'b00;
        if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == Rs2E_i)) begin
            ForwardBE_o = 2'b10;
        end else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == Rs2E_i)) begin
            ForwardBE_o = 2'b01;
        end
    end
`else
    logic raw_e;
    logic raw_m;
    logic unused_fwd;

    // Without forwarding, any in-flight producer in E or M blocks the consumer in D.
    assign raw_e = RegWriteE_i && (RdE_i != 5'd0) && ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    assign raw_m = RegWriteM_i && (RdM_i != 5'd0) && ((RdM_i == Rs1D_i) || (RdM_i == Rs2D_i));
    assign raw_stall = ld_use || raw_e || raw_m;

    assign ForwardAE_o = 2'b00;
    assign ForwardBE_o = 2'b00;
    assign unused_fwd  = ^{Rs1E_i, Rs2E_i, RdW_i, RegWriteW_i};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            StRun: begin
                if (MemReqM_i && !MemReadyM_i) begin
                    state_d    = StMemWait;
                    wait_cnt_d = '0;
                end
            end
            StMemWait: begin
                wait_cnt_d = wait_cnt_q + WaitW'(1);
                if (MemReadyM_i) begin
                    state_d = StRun;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d = StRun;
                    err_d   = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
        if (StallF_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Priority: reset, then memory wait, then branch flush, then RAW/load-use stall.
    always_comb begin
        StallF_o  = 1'b0;
        StallD_o  = 1'b0;
        StallE_o  = 1'b0;
        StallM_o  = 1'b0;
        FlushD_o  = 1'b0;
        FlushE_o  = 1'b0;
        BubbleW_o = 1'b0;
        if (!rst) begin
            if (mem_busy) begin
                StallF_o  = 1'b1;
                StallD_o  = 1'b1;
                StallE_o  = 1'b1;
                StallM_o  = 1'b1;
                BubbleW_o = 1'b1;
            end else if (PCSrcE_i) begin
                FlushD_o = 1'b1;
                FlushE_o = 1'b1;
            end else if (raw_stall) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                FlushE_o = 1'b1;
            end
        end
    end

    assign err_o       = err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
